leibniz_term_sequencer: RTL and testbench
=========================================

LEIBNIZ_TERM_SEQUENCER -- requirements
Module: leibniz_term_sequencer

Interface
REQ-001 Parameter P_WIDTH, default 32: divider operand width.
REQ-002 Parameter P_ACC_WIDTH, default 40: signed accumulator and result width.
REQ-003 Parameter P_TIMEOUT, default 64: maximum cycles spent waiting for div_done.
REQ-004 clk  in  1  clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  single-cycle request to compute; sampled in IDLE only.
REQ-007 n_terms  in  16  number of series terms; sampled with start.
REQ-008 scale  in  P_WIDTH  numerator for every term; sampled with start.
REQ-009 div_start  out  1  one-cycle launch pulse to the divider.
REQ-010 div_dividend  out  P_WIDTH  dividend to the divider.
REQ-011 div_divisor  out  P_WIDTH  divisor to the divider (2k+1).
REQ-012 div_quotient  in  P_WIDTH  divider quotient, valid with div_done.
REQ-013 div_done  in  1  divider completion pulse.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 pi_out  out  P_ACC_WIDTH  signed result, 4*sum((-1)^k*floor(scale/(2k+1))) for k = 0..n_terms-1.
REQ-016 pi_valid  out  1  one-cycle pulse when pi_out is updated.
REQ-017 err  out  1  set on divider timeout, cleared at the next accepted start.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT, ACCUM, FINAL.
REQ-019 In IDLE, start with n_terms!=0 SHALL do the following, then go to ISSUE:
- latch n_terms and scale;
- clear acc, k and err.
REQ-020 In IDLE, start with n_terms==0 SHALL go to FINAL with acc=0 and issue no div_start.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 ISSUE SHALL assert div_start for exactly one cycle and then go to WAIT.
REQ-023 div_dividend SHALL equal the latched scale, and div_divisor SHALL equal 2k+1 zero-extended.
- Both SHALL hold stable from ISSUE through the end of WAIT.
REQ-024 In WAIT, div_done=1 SHALL capture div_quotient and go to ACCUM.
- div_done in any other state SHALL be ignored.
REQ-025 A WAIT watchdog SHALL count cycles in WAIT. When it reaches P_TIMEOUT without div_done, the block SHALL:
- set err=1;
- force acc=0;
- go to FINAL.
REQ-026 ACCUM SHALL:
- add the zero-extended quotient to acc when k is even, and subtract it when k is odd;
- increment k;
- go to FINAL if k+1==n_terms, otherwise go to ISSUE.
REQ-027 FINAL SHALL do the following, then return to IDLE:
- load pi_out with acc shifted left by 2;
- pulse pi_valid for one cycle on the following cycle;
- hold pi_out until the next pi_valid.
REQ-028 Arithmetic SHALL be two's complement in P_ACC_WIDTH with no saturation. The partial sums are bounded by scale, so P_ACC_WIDTH >= P_WIDTH+3 is sufficient.
REQ-029 Per-term latency SHALL be 1 (ISSUE) + divider latency + 1 (ACCUM) cycles.
REQ-030 div_start SHALL never be asserted while a previous division is outstanding.

Reset
REQ-031 While rst_n=0, the following SHALL hold:
- state=IDLE;
- div_start=0, div_dividend=0, div_divisor=0;
- busy=0, pi_out=0, pi_valid=0, err=0;
- acc, k and the watchdog cleared.
REQ-032 Reset asserted mid-operation SHALL abort immediately, discard any later div_done, and require a new start.

Verification
REQ-033 scale=1000, n_terms=1 -> one div_start with divisor=1, then pi_out=4000, pi_valid pulse, err=0.
REQ-034 scale=1000, n_terms=4 -> divisors 1,3,5,7 in order and quotients 1000,333,200,142, then pi_out=2900.
REQ-035 n_terms=0 -> no div_start, pi_valid pulse with pi_out=0, busy high for exactly 2 cycles.
REQ-036 Divider model never returns div_done -> err=1 after 64 WAIT cycles, then pi_valid with pi_out=0; the next start clears err.
REQ-037 scale=0xFFFFFFFF, n_terms=1 -> pi_out=0x3FFFFFFFC. A second start pulsed during WAIT -> ignored and does not change the result.
REQ-038 rst_n low during WAIT of term 2 -> all outputs at reset values. A div_done pulse after release -> no state change. A fresh run -> correct result.

Source files
------------

// File: rtl/leibniz_term_sequencer.sv
// Sequences the Leibniz series terms through an external divider and
// accumulates 4*sum((-1)^k * floor(scale/(2k+1))) for k = 0..n_terms-1.
module leibniz_term_sequencer #(
  parameter int P_WIDTH     = 32,
  parameter int P_ACC_WIDTH = 40,
  parameter int P_TIMEOUT   = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [15:0]                   n_terms,
  input  logic [P_WIDTH-1:0]            scale,
  output logic                          div_start,
  output logic [P_WIDTH-1:0]            div_dividend,
  output logic [P_WIDTH-1:0]            div_divisor,
  input  logic [P_WIDTH-1:0]            div_quotient,
  input  logic                          div_done,
  output logic                          busy,
  output logic signed [P_ACC_WIDTH-1:0] pi_out,
  output logic                          pi_valid,
  output logic                          err
);

  localparam int WD_W = $clog2(P_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(P_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACCUM,
    S_FINAL
  } state_t;

  state_t                          state;
  logic [15:0]                     n_lat;
  logic [P_WIDTH-1:0]              scale_lat;
  logic signed [P_ACC_WIDTH-1:0]   acc;
  logic [15:0]                     k;
  logic [WD_W-1:0]                 wd;
  logic [P_WIDTH-1:0]              quot;
  logic                            final_hold;

  logic [15:0]                     k_inc;
  logic [P_ACC_WIDTH-1:0]          quot_ext;

  assign k_inc    = k + 16'd1;
  assign quot_ext = P_ACC_WIDTH'(quot);

  // Divisor for term kk is 2kk+1, zero-extended to the divider width.
  function automatic logic [P_WIDTH-1:0] odd_of(input logic [15:0] kk);
    return P_WIDTH'({kk, 1'b1});
  endfunction

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      n_lat        <= '0;
      scale_lat    <= '0;
      acc          <= '0;
      k            <= '0;
      wd           <= '0;
      quot         <= '0;
      final_hold   <= 1'b0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      busy         <= 1'b0;
      pi_out       <= '0;
      pi_valid     <= 1'b0;
      err          <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle; only the launching
      // branch raises them, so they can never stick high.
      div_start <= 1'b0;
      pi_valid  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            n_lat     <= n_terms;
            scale_lat <= scale;
            acc       <= '0;
            k         <= '0;
            wd        <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            if (n_terms == 16'd0) begin
              state <= S_FINAL;
            end else begin
              state        <= S_ISSUE;
              div_start    <= 1'b1;
              div_dividend <= scale;
              div_divisor  <= odd_of(16'd0);
            end
          end
        end

        S_ISSUE: begin
          wd    <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (div_done) begin
            quot  <= div_quotient;
            state <= S_ACCUM;
          end else if (wd == WD_LAST) begin
            // Divider never answered: report and publish a zero result.
            err   <= 1'b1;
            acc   <= '0;
            state <= S_FINAL;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        S_ACCUM: begin
          if (k[0]) acc <= acc - $signed(quot_ext);
          else      acc <= acc + $signed(quot_ext);
          k <= k_inc;
          if (k_inc == n_lat) begin
            state <= S_FINAL;
          end else begin
            state        <= S_ISSUE;
            div_start    <= 1'b1;
            div_dividend <= scale_lat;
            div_divisor  <= odd_of(k_inc);
          end
        end

        S_FINAL: begin
          // Two cycles: load the result, then present it with pi_valid
          // while still busy.
          if (!final_hold) begin
            pi_out     <= acc <<< 2;
            pi_valid   <= 1'b1;
            final_hold <= 1'b1;
          end else begin
            final_hold <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leibniz_term_sequencer.sv
// Scoreboard bench for leibniz_term_sequencer: a behavioural divider answers
// div_start, monitors pop expected divisor/result entries queued by stimulus.
module tb_leibniz_term_sequencer;

  localparam int W  = 32;
  localparam int AW = 40;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [15:0]          n_terms = '0;
  logic [W-1:0]         scale = '0;
  logic                 div_start;
  logic [W-1:0]         div_dividend;
  logic [W-1:0]         div_divisor;
  logic [W-1:0]         div_quotient;
  logic                 div_done;
  logic                 busy;
  logic signed [AW-1:0] pi_out;
  logic                 pi_valid;
  logic                 err;

  leibniz_term_sequencer #(.P_WIDTH(W), .P_ACC_WIDTH(AW), .P_TIMEOUT(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .n_terms      (n_terms),
    .scale        (scale),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_done     (div_done),
    .busy         (busy),
    .pi_out       (pi_out),
    .pi_valid     (pi_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] dividend; logic [W-1:0] divisor; } div_exp_t;
  typedef struct { logic [AW-1:0] pi; logic err; } res_exp_t;

  div_exp_t div_q[$];
  res_exp_t res_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int pv_count = 0;
  int ds_count = 0;
  int div_lat = 1;
  logic div_mute = 1'b0;
  int inj_req = 0;
  logic [W-1:0] inj_q = '0;

  // divider model state (owned by the divider process)
  logic drv_pend = 1'b0;
  int drv_cnt = 0;
  int drv_inj_seen = 0;
  logic [W-1:0] drv_q = '0;
  logic [W-1:0] drv_div = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Divider model and div_start monitor.
  initial begin
    div_done = 1'b0;
    div_quotient = '0;
    forever begin
      @(posedge clk);
      #1;
      div_done = 1'b0;
      if (!rst_n) begin
        drv_pend = 1'b0;
      end else if (inj_req != drv_inj_seen) begin
        drv_inj_seen = inj_req;
        div_done = 1'b1;
        div_quotient = inj_q;
      end else if (drv_pend) begin
        drv_cnt--;
        if (drv_cnt == 0) begin
          check("divisor_stable", div_divisor, drv_div);
          div_done = 1'b1;
          div_quotient = drv_q;
          drv_pend = 1'b0;
        end
      end
      @(negedge clk);
      if (!rst_n) begin
        drv_pend = 1'b0;
      end else if (div_start) begin
        ds_count++;
        check("no_outstanding_div", drv_pend, 1'b0);
        if (div_q.size() == 0) begin
          check("unexpected_div_start", 1, 0);
        end else begin
          div_exp_t e;
          e = div_q.pop_front();
          check("div_divisor", div_divisor, e.divisor);
          check("div_dividend", div_dividend, e.dividend);
        end
        if (!div_mute) begin
          drv_pend = 1'b1;
          drv_cnt  = div_lat;
          drv_q    = div_dividend / div_divisor;
          drv_div  = div_divisor;
        end
      end
    end
  end

  // Result monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && pi_valid) begin
        pv_count++;
        if (res_q.size() == 0) begin
          check("unexpected_pi_valid", 1, 0);
        end else begin
          res_exp_t r;
          r = res_q.pop_front();
          check("pi_out", pi_out, r.pi);
          check("err", err, r.err);
        end
      end
    end
  end

  task automatic expect_run(input logic [W-1:0] s, input int ndiv,
                            input logic [AW-1:0] pi, input logic e);
    for (int i = 0; i < ndiv; i++) div_q.push_back('{s, W'(2 * i + 1)});
    res_q.push_back('{pi, e});
  endtask

  task automatic issue(input logic [W-1:0] s, input logic [15:0] n);
    @(posedge clk);
    #1;
    scale = s;
    n_terms = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_result(input int base);
    int i;
    i = 0;
    while (pv_count == base && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (pv_count == base) check("result_timeout", 0, 1);
  endtask

  task automatic run(input logic [W-1:0] s, input logic [15:0] n, input int ndiv,
                     input logic [AW-1:0] pi, input logic e);
    int base;
    base = pv_count;
    expect_run(s, ndiv, pi, e);
    issue(s, n);
    wait_result(base);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_div_start"}, div_start, 0);
    check({tag, "_div_dividend"}, div_dividend, 0);
    check({tag, "_div_divisor"}, div_divisor, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pi_out"}, pi_out, 0);
    check({tag, "_pi_valid"}, pi_valid, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int base;
    int cnt;
    int ds_base;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single term: divisor 1, result 4*1000.
    div_lat = 1;
    run(32'd1000, 16'd1, 1, 40'd4000, 1'b0);

    // Four terms: 1000-333+200-142 = 725 -> 2900.
    div_lat = 2;
    run(32'd1000, 16'd4, 4, 40'd2900, 1'b0);

    // Three terms, slower divider: 100-33+20 = 87 -> 348.
    div_lat = 4;
    run(32'd100, 16'd3, 3, 40'd348, 1'b0);

    // Two terms: 10-3 = 7 -> 28.
    div_lat = 1;
    run(32'd10, 16'd2, 2, 40'd28, 1'b0);

    // Zero terms: no division, busy for exactly two cycles.
    ds_base = ds_count;
    base = pv_count;
    expect_run(32'd55, 0, 40'd0, 1'b0);
    issue(32'd55, 16'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("zero_terms_busy_cycles", cnt, 2);
    check("zero_terms_div_starts", ds_count - ds_base, 0);
    wait_result(base);

    // Divider never answers: err after 64 WAIT cycles, result 0.
    div_mute = 1'b1;
    base = pv_count;
    expect_run(32'd1000, 1, 40'd0, 1'b1);
    issue(32'd1000, 16'd3);
    cnt = 0;
    while (!err && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_cycles_to_err", cnt, 66);
    wait_result(base);
    @(negedge clk);
    check("err_held_in_idle", err, 1);
    div_mute = 1'b0;

    // Next accepted start clears err.
    base = pv_count;
    expect_run(32'd1000, 1, 40'd4000, 1'b0);
    issue(32'd1000, 16'd1);
    @(negedge clk);
    check("err_cleared_on_start", err, 0);
    wait_result(base);

    // Full-scale dividend; a start during WAIT must be ignored.
    div_lat = 5;
    base = pv_count;
    ds_base = ds_count;
    expect_run(32'hFFFF_FFFF, 1, 40'h3_FFFF_FFFC, 1'b0);
    issue(32'hFFFF_FFFF, 16'd1);
    cnt = 0;
    while (ds_count == ds_base && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    issue(32'd7, 16'd3);
    wait_result(base);
    check("ignored_start_div_count", ds_count - ds_base, 1);

    // Reset during WAIT of term 2, stray div_done afterwards, then fresh run.
    div_lat = 3;
    ds_base = ds_count;
    div_q.push_back('{32'd1000, 32'd1});
    div_q.push_back('{32'd1000, 32'd3});
    issue(32'd1000, 16'd4);
    cnt = 0;
    while (ds_count < ds_base + 2 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("reset_test_reached_term2", ds_count - ds_base, 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    inj_q = 32'd333;
    inj_req++;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || pi_valid || div_start) cnt++;
    end
    check("stray_done_no_activity", cnt, 0);
    div_lat = 1;
    run(32'd1000, 16'd4, 4, 40'd2900, 1'b0);

    repeat (3) @(negedge clk);
    check("div_queue_drained", div_q.size(), 0);
    check("result_queue_drained", res_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
